// File: rtl/mem_stage_hs.sv
// ----------------------------------------------------------------------------
// mem_stage_hs -- MEM pipeline stage with a ready/valid memory handshake.
//
// Registers one EX-stage result per transaction. Non-memory ops pass straight
// through to WB with one cycle of latency. Loads and stores are latched and
// presented on the memory port until mem_ready completes them or the wait
// counter reaches TMO, at which point the access is aborted. Upstream is
// stalled for as long as an access is outstanding.
//
// Memory handshake: while mem_req is high, mem_addr, mem_we and mem_wdata
// hold their values. The transfer completes on the rising edge where both
// mem_req and mem_ready are high. mem_ready is ignored while mem_req is low.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   in_valid          EX result present (ignored while an access is pending)
//   in_mem, in_we     op is a load/store; op is a store
//   in_addr           ALU result / memory address
//   in_wdata          store data
//   in_wb             write-back control {en, dest[2:0], mux}, en at WB-1
//   src_sel           read-source select, sampled with in_valid
//   stall_out         upstream must hold its inputs
//   mem_req, mem_we   access request, write strobe
//   mem_addr          access address
//   mem_wdata         store data
//   mem_ready         access completes this cycle
//   mem_rdata         NSRC read sources, source i at [i*DW +: DW]
//   out_valid         one-cycle result pulse to WB
//   out_alu           registered ALU result / address
//   out_rdata         registered load data
//   out_wb            registered write-back control
//   mem_op_dest       in_wb[3:1], combinational, for the hazard unit
//   err_clr           clears tmo_err
//   tmo_err           sticky timeout flag
//   state_dbg         current FSM state (0 = IDLE, 1 = ACCESS)
// ----------------------------------------------------------------------------
module mem_stage_hs #(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int WB   = 5,
    parameter int NSRC = 2,
    parameter int SELW = 1,
    parameter int TMO  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_mem,
    input  logic                 in_we,
    input  logic [AW-1:0]        in_addr,
    input  logic [DW-1:0]        in_wdata,
    input  logic [WB-1:0]        in_wb,
    input  logic [SELW-1:0]      src_sel,
    output logic                 stall_out,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic                 mem_ready,
    input  logic [NSRC*DW-1:0]   mem_rdata,
    output logic                 out_valid,
    output logic [AW-1:0]        out_alu,
    output logic [DW-1:0]        out_rdata,
    output logic [WB-1:0]        out_wb,
    output logic [2:0]           mem_op_dest,
    input  logic                 err_clr,
    output logic                 tmo_err,
    output logic                 state_dbg
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] TMO_C = 8'(TMO);

    state_t            state_q;
    state_t            state_d;

    // Request latches, captured when a memory op is accepted.
    logic [AW-1:0]     addr_q;
    logic              we_q;
    logic [DW-1:0]     wdata_q;
    logic [WB-1:0]     wb_q;
    logic [SELW-1:0]   sel_q;
    logic [7:0]        cnt_q;

    logic              accept_alu;
    logic              accept_mem;
    logic              acc_done;
    logic              acc_tmo;
    logic [7:0]        cnt_inc;
    logic [DW-1:0]     sel_data;

    assign accept_alu = (state_q == S_IDLE) && in_valid && !in_mem;
    assign accept_mem = (state_q == S_IDLE) && in_valid && in_mem;

    // Saturating increment: the counter never wraps back under TMO.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Completion takes priority: a ready in the cycle the count would reach
    // TMO is a normal completion. The abort fires at the end of the TMO-th
    // consecutive cycle without ready.
    assign acc_done = (state_q == S_ACCESS) && mem_ready;
    assign acc_tmo  = (state_q == S_ACCESS) && !mem_ready && (cnt_inc >= TMO_C);

    assign mem_op_dest = in_wb[3:1];
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign state_dbg   = state_q;

    // Read-source mux; a select with no matching source returns zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel_q) == i) begin
                sel_data = mem_rdata[i*DW +: DW];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept_mem) state_d = S_ACCESS;
            S_ACCESS: if (acc_done || acc_tmo) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs (purely from state, so reset drops them immediately)
    always_comb begin
        mem_req   = 1'b0;
        stall_out = 1'b0;
        mem_we    = 1'b0;
        if (state_q == S_ACCESS) begin
            mem_req   = 1'b1;
            stall_out = 1'b1;
            mem_we    = we_q;
        end
    end

    // Datapath: request latches, wait counter, result registers, error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wb_q      <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_alu   <= '0;
            out_rdata <= '0;
            out_wb    <= '0;
            tmo_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (accept_alu) begin
                out_valid <= 1'b1;
                out_alu   <= in_addr;
                out_rdata <= '0;
                out_wb    <= in_wb;
            end

            if (accept_mem) begin
                addr_q  <= in_addr;
                we_q    <= in_we;
                wdata_q <= in_wdata;
                wb_q    <= in_wb;
                sel_q   <= src_sel;
                cnt_q   <= '0;
            end

            if (acc_done) begin
                out_valid <= 1'b1;
                out_alu   <= addr_q;
                out_rdata <= we_q ? '0 : sel_data;
                out_wb    <= wb_q;
            end else if (acc_tmo) begin
                // Aborted op: poison data and suppress the register write.
                out_valid <= 1'b1;
                out_alu   <= addr_q;
                out_rdata <= '1;
                out_wb    <= {1'b0, wb_q[WB-2:0]};
            end else if (state_q == S_ACCESS) begin
                cnt_q <= cnt_inc;
            end

            // Set has priority over clear.
            if (acc_tmo) begin
                tmo_err <= 1'b1;
            end else if (err_clr) begin
                tmo_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_hs -- self-checking bench for mem_stage_hs.
//
// Two instances share the stimulus: u_dut with two read sources and u_dut1
// with a single source, so that src_sel=1 is an invalid select for u_dut1.
// Expected results are queued by the driver tasks with the cycle they are due
// and compared whenever a cycle ends.
// ----------------------------------------------------------------------------
module tb_mem_stage_hs;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int WB    = 5;
    localparam int NSRC  = 2;
    localparam int SELW  = 1;
    localparam int TMO   = 15;
    localparam int EXP_W = 32 + AW + DW + DW + WB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT signals ----------------
    logic                 in_valid, in_mem, in_we;
    logic [AW-1:0]        in_addr;
    logic [DW-1:0]        in_wdata;
    logic [WB-1:0]        in_wb;
    logic [SELW-1:0]      src_sel;
    logic                 stall_out, mem_req, mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_ready;
    logic [NSRC*DW-1:0]   mem_rdata;
    logic                 out_valid;
    logic [AW-1:0]        out_alu;
    logic [DW-1:0]        out_rdata;
    logic [WB-1:0]        out_wb;
    logic [2:0]           mem_op_dest;
    logic                 err_clr;
    logic                 tmo_err;
    logic                 state_dbg;

    logic [DW-1:0]        mem_rdata1;
    logic                 dut1_stall_out, dut1_mem_req, dut1_mem_we;
    logic [AW-1:0]        dut1_mem_addr;
    logic [DW-1:0]        dut1_mem_wdata;
    logic                 dut1_out_valid;
    logic [AW-1:0]        dut1_out_alu;
    logic [DW-1:0]        dut1_out_rdata;
    logic [WB-1:0]        dut1_out_wb;
    logic [2:0]           dut1_mem_op_dest;
    logic                 dut1_tmo_err;
    logic                 dut1_state_dbg;

    assign mem_rdata1 = mem_rdata[DW-1:0];

    mem_stage_hs #(.DW(DW), .AW(AW), .WB(WB), .NSRC(NSRC), .SELW(SELW), .TMO(TMO)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_mem(in_mem), .in_we(in_we),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_wb(in_wb), .src_sel(src_sel),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_alu(out_alu), .out_rdata(out_rdata), .out_wb(out_wb),
        .mem_op_dest(mem_op_dest), .err_clr(err_clr), .tmo_err(tmo_err),
        .state_dbg(state_dbg)
    );

    mem_stage_hs #(.DW(DW), .AW(AW), .WB(WB), .NSRC(1), .SELW(SELW), .TMO(TMO)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_mem(in_mem), .in_we(in_we),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_wb(in_wb), .src_sel(src_sel),
        .stall_out(dut1_stall_out), .mem_req(dut1_mem_req), .mem_we(dut1_mem_we),
        .mem_addr(dut1_mem_addr), .mem_wdata(dut1_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata1),
        .out_valid(dut1_out_valid), .out_alu(dut1_out_alu), .out_rdata(dut1_out_rdata),
        .out_wb(dut1_out_wb), .mem_op_dest(dut1_mem_op_dest), .err_clr(err_clr),
        .tmo_err(dut1_tmo_err), .state_dbg(dut1_state_dbg)
    );

    // ---------------- scoreboard ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_out_cyc = 0;
    int   last_acc_cyc = 0;
    logic tmo_exp = 1'b0;
    // {due cycle, alu, rdata, rdata for single-source instance, wb}
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] alu, input logic [DW-1:0] rd,
                            input logic [DW-1:0] rd1, input logic [WB-1:0] wb);
        exp_q.push_back({32'(cyc + 1), alu, rd, rd1, wb});
    endtask

    // Advance one cycle and compare the result port against the queue.
    task automatic tick();
        logic [31:0]   due;
        logic [AW-1:0] e_alu;
        logic [DW-1:0] e_rd, e_rd1;
        logic [WB-1:0] e_wb;
        logic          exp_v;
        @(posedge clk);
        #1;
        cyc++;
        while (exp_q.size() != 0) begin
            {due, e_alu, e_rd, e_rd1, e_wb} = exp_q[0];
            if (due < 32'(cyc)) void'(exp_q.pop_front());
            else break;
        end
        exp_v = (exp_q.size() != 0) && (due == 32'(cyc));
        check("out_valid", out_valid, exp_v);
        check("dut1_out_valid", dut1_out_valid, exp_v);
        if (out_valid) last_out_cyc = cyc;
        if (exp_v && out_valid) begin
            void'(exp_q.pop_front());
            check("out_alu", out_alu, e_alu);
            check("out_rdata", out_rdata, e_rd);
            check("out_wb", out_wb, e_wb);
            check("dut1_out_rdata", dut1_out_rdata, e_rd1);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle(input logic clr);
        in_valid  = 1'b0;
        in_mem    = 1'($urandom);
        in_we     = 1'($urandom);
        in_addr   = AW'($urandom);
        in_wdata  = DW'($urandom);
        in_wb     = WB'($urandom);
        src_sel   = SELW'($urandom);
        mem_ready = 1'($urandom);
        mem_rdata = (NSRC*DW)'($urandom);
        err_clr   = clr;
        #1;
        check("mem_op_dest", mem_op_dest, in_wb[3:1]);
        check("idle_stall_out", stall_out, 1'b0);
        check("idle_mem_req", mem_req, 1'b0);
        check("idle_mem_we", mem_we, 1'b0);
        tick();
        if (clr) tmo_exp = 1'b0;
        check("tmo_err", tmo_err, tmo_exp);
        err_clr = 1'b0;
    endtask

    task automatic do_alu(input logic [AW-1:0] a, input logic [WB-1:0] w);
        in_valid  = 1'b1;
        in_mem    = 1'b0;
        in_we     = 1'($urandom);
        in_addr   = a;
        in_wdata  = DW'($urandom);
        in_wb     = w;
        src_sel   = SELW'($urandom);
        mem_ready = 1'($urandom);
        mem_rdata = (NSRC*DW)'($urandom);
        err_clr   = 1'b0;
        #1;
        check("mem_op_dest", mem_op_dest, w[3:1]);
        check("alu_stall_out", stall_out, 1'b0);
        check("alu_mem_req", mem_req, 1'b0);
        push_exp(a, '0, '0, w);
        tick();
    endtask

    // waits: cycles with mem_ready low before it rises; waits >= TMO never
    // raises it, so the access times out after TMO low cycles.
    task automatic do_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [WB-1:0] w, input logic [SELW-1:0] sel, input int waits,
                          input logic clr_last, input logic use_fix,
                          input logic [NSRC*DW-1:0] fix_rdata);
        logic          tmo;
        int            n;
        logic [DW-1:0] rd, rd1;
        tmo = (waits >= TMO);
        n   = tmo ? TMO : waits + 1;
        in_valid  = 1'b1;
        in_mem    = 1'b1;
        in_we     = we;
        in_addr   = a;
        in_wdata  = wd;
        in_wb     = w;
        src_sel   = sel;
        mem_ready = 1'($urandom);
        mem_rdata = (NSRC*DW)'($urandom);
        err_clr   = 1'b0;
        #1;
        check("mem_op_dest", mem_op_dest, w[3:1]);
        check("accept_stall_out", stall_out, 1'b0);
        last_acc_cyc = cyc;
        tick();
        for (int k = 0; k < n; k++) begin
            // Upstream garbage while stalled must be ignored.
            in_valid  = 1'($urandom);
            in_mem    = 1'($urandom);
            in_we     = 1'($urandom);
            in_addr   = AW'($urandom);
            in_wdata  = DW'($urandom);
            in_wb     = WB'($urandom);
            src_sel   = SELW'($urandom);
            mem_rdata = use_fix ? fix_rdata : (NSRC*DW)'($urandom);
            mem_ready = !tmo && (k == waits);
            err_clr   = clr_last && (k == n - 1);
            #1;
            check("mem_op_dest_stall", mem_op_dest, in_wb[3:1]);
            check("acc_stall_out", stall_out, 1'b1);
            check("acc_mem_req", mem_req, 1'b1);
            check("acc_mem_addr", mem_addr, a);
            check("acc_mem_we", mem_we, we);
            check("acc_mem_wdata", mem_wdata, wd);
            if (k == n - 1) begin
                if (tmo) begin
                    push_exp(a, '1, '1, {1'b0, w[WB-2:0]});
                end else begin
                    rd  = '0;
                    rd1 = '0;
                    if (!we && int'(sel) < NSRC) rd = mem_rdata[int'(sel)*DW +: DW];
                    if (!we && sel == '0) rd1 = mem_rdata[DW-1:0];
                    push_exp(a, rd, rd1, w);
                end
            end
            tick();
        end
        err_clr = 1'b0;
        if (tmo) tmo_exp = 1'b1;
        else if (clr_last) tmo_exp = 1'b0;
        check("mem_req_released", mem_req, 1'b0);
        check("tmo_err_after_mem", tmo_err, tmo_exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_stall_out"}, stall_out, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_mem_wdata"}, mem_wdata, '0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_alu"}, out_alu, '0);
        check({tag, "_out_rdata"}, out_rdata, '0);
        check({tag, "_out_wb"}, out_wb, '0);
        check({tag, "_tmo_err"}, tmo_err, 1'b0);
        check({tag, "_state"}, state_dbg, 1'b0);
    endtask

    // Load with three wait states, reset asserted in the third ACCESS cycle.
    task automatic do_reset_mid();
        in_valid  = 1'b1;
        in_mem    = 1'b1;
        in_we     = 1'b0;
        in_addr   = 16'h0044;
        in_wdata  = 16'h0000;
        in_wb     = 5'b10110;
        src_sel   = 1'b0;
        mem_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b0;
            #1;
            check("rstmid_mem_req", mem_req, 1'b1);
            tick();
        end
        rst = 1'b0;
        #1;
        check_all_zero("rstmid");
        tmo_exp   = 1'b0;
        mem_ready = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) drive_idle(1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_mem    = 1'b0;
        in_we     = 1'b0;
        in_addr   = '0;
        in_wdata  = '0;
        in_wb     = '0;
        src_sel   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        err_clr   = 1'b0;

        // Reset defaults
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b1;
        drive_idle(1'b0);

        // Non-memory stream, back to back
        for (int i = 0; i < 4; i++) do_alu(AW'(16'h0010 + i), WB'($urandom));
        drive_idle(1'b0);

        // Load from source 1 with two wait states
        do_mem(1'b0, 16'h00A4, 16'h0000, 5'b11010, 1'b1, 2, 1'b0, 1'b1, 32'hBEEF_1234);
        check("load_latency", last_out_cyc - last_acc_cyc, 4);
        drive_idle(1'b0);

        // Zero-wait store
        do_mem(1'b1, 16'h0020, 16'h5A5A, 5'b00001, 1'b0, 0, 1'b0, 1'b0, '0);
        check("store_latency", last_out_cyc - last_acc_cyc, 2);

        // Timeout, then clear
        do_mem(1'b0, 16'h0030, 16'h0000, 5'b11111, 1'b0, TMO, 1'b0, 1'b0, '0);
        check("tmo_latency", last_out_cyc - last_acc_cyc, TMO + 1);
        drive_idle(1'b1);

        // Ready on the last allowed wait cycle completes normally
        do_mem(1'b0, 16'h0031, 16'h0000, 5'b10101, 1'b1, TMO - 1, 1'b0, 1'b1, 32'hCAFE_0F0F);
        check("late_ready_latency", last_out_cyc - last_acc_cyc, TMO + 1);
        drive_idle(1'b0);

        // Timeout with err_clr on the same edge: set wins
        do_mem(1'b0, 16'h0032, 16'h0000, 5'b10011, 1'b0, TMO, 1'b1, 1'b0, '0);
        drive_idle(1'b1);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            int r;
            int w;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                drive_idle(1'($urandom_range(0, 3) == 0));
            end else if (r == 1) begin
                do_alu(AW'($urandom), WB'($urandom));
            end else begin
                w = ($urandom_range(0, 4) == 0) ? $urandom_range(TMO - 1, TMO + 1)
                                                : $urandom_range(0, 4);
                do_mem(1'($urandom), AW'($urandom), DW'($urandom), WB'($urandom),
                       SELW'($urandom), w, 1'b0, 1'b0, '0);
            end
        end

        // Reset in the middle of an access, with tmo_err set beforehand
        do_mem(1'b0, 16'h0050, 16'h0000, 5'b11100, 1'b0, TMO, 1'b0, 1'b0, '0);
        do_reset_mid();

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
